// File: rtl/mux4_rr_pkg.sv
// Shared constants, types and helpers for the mux4_rr round-robin gathering multiplexer.
package mux4_rr_pkg;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    function automatic logic [NUM_IN-1:0] sel_onehot(input sel_t s);
        logic [NUM_IN-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: highest priority at ptr, then ptr+1, ... wrapping mod 4.
module rr_arbiter4
    import mux4_rr_pkg::*;
(
    input  logic [NUM_IN-1:0] req,
    input  sel_t              ptr,
    output logic [NUM_IN-1:0] grant,
    output sel_t              grant_idx,
    output logic              any_grant
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            sel_t idx;
            idx = sel_t'(ptr + sel_t'(k));
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant_idx = idx;
                grant     = sel_onehot(idx);
            end
        end
    end

endmodule

// File: rtl/mux4_rr.sv
// Four-input round-robin valid/ready multiplexer with registered output and channel tag.
// Define MUX4_RR_LOCK_EN to hold the grant on one channel until its in_last beat (packet lock).
module mux4_rr
    import mux4_rr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
`ifdef MUX4_RR_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output sel_t                    out_sel,
    input  logic                    out_ready
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    sel_t              r_out_sel;
    sel_t              r_ptr;

    logic              w_load_en;
    logic [NUM_IN-1:0] w_arb_grant;
    sel_t              w_arb_idx;
    logic              w_arb_any;
    logic [NUM_IN-1:0] w_grant;
    sel_t              w_grant_idx;
    logic              w_any;
    logic              w_xfer;
    logic              w_ptr_upd;
    logic [WIDTH-1:0]  w_sel_data;

    assign w_load_en = !r_out_valid || out_ready;

    rr_arbiter4 u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .any_grant (w_arb_any)
    );

`ifdef MUX4_RR_LOCK_EN
    state_t r_state;
    state_t w_state_nxt;
    sel_t   r_lock_ch;
    sel_t   w_lock_ch_nxt;
    logic   r_out_last;
    logic   w_xfer_last;

    // While locked the arbiter is bypassed; an idle locked channel simply produces bubbles.
    always_comb begin
        w_grant     = w_arb_grant;
        w_grant_idx = w_arb_idx;
        w_any       = w_arb_any;
        if (r_state == LOCKED) begin
            w_grant_idx = r_lock_ch;
            w_any       = in_valid[r_lock_ch];
            w_grant     = w_any ? sel_onehot(r_lock_ch) : '0;
        end
    end

    assign w_xfer      = w_load_en && w_any;
    assign w_xfer_last = in_last[w_grant_idx];
    assign w_ptr_upd   = w_xfer && w_xfer_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_ch_nxt = r_lock_ch;
        case (r_state)
            ARB: begin
                if (w_xfer && !w_xfer_last) begin
                    w_state_nxt   = LOCKED;
                    w_lock_ch_nxt = w_grant_idx;
                end
            end
            LOCKED: begin
                if (w_xfer && w_xfer_last) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_lock_ch  <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_ch_nxt;
            if (w_xfer) begin
                r_out_last <= w_xfer_last;
            end
        end
    end

    assign out_last = r_out_last;
`else
    assign w_grant     = w_arb_grant;
    assign w_grant_idx = w_arb_idx;
    assign w_any       = w_arb_any;
    assign w_xfer      = w_load_en && w_any;
    assign w_ptr_upd   = w_xfer;
`endif

    assign w_sel_data = in_data[w_grant_idx*WIDTH +: WIDTH];
    assign in_ready   = rst ? '0 : ({NUM_IN{w_load_en}} & w_grant);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_any;
                if (w_any) begin
                    r_out_data <= w_sel_data;
                    r_out_sel  <= w_grant_idx;
                end
            end
            if (w_ptr_upd) begin
                r_ptr <= sel_t'(w_grant_idx + 1'b1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux4_rr.sv
// Directed self-checking bench for mux4_rr; lock scenarios run when MUX4_RR_LOCK_EN is defined.
module tb_mux4_rr;
    import mux4_rr_pkg::*;

    localparam int WIDTH = 8;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    sel_t                    out_sel;
    logic                    out_ready;
`ifdef MUX4_RR_LOCK_EN
    logic [NUM_IN-1:0]       in_last;
    logic                    out_last;
`endif

    int n_vec;
    int n_bad;

    mux4_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef MUX4_RR_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d, input sel_t s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef MUX4_RR_LOCK_EN
        in_last   = 4'b1111;
`endif
        for (int i = 0; i < NUM_IN; i++) set_data(i, WIDTH'(8'h10 + i));

        // Reset held two cycles with all requesters active.
        tick();
        check("rst.ready0", 32'(in_ready), 32'h0);
        tick();
        check("rst.valid", 32'(out_valid), 32'h0);
        check("rst.sel", 32'(out_sel), 32'h0);
        check("rst.data", 32'(out_data), 32'h0);
        check("rst.ready1", 32'(in_ready), 32'h0);

        // Fairness: sequence 0,1,2,3,0,1 back to back.
        rst = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fair%0d.ready", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check_out($sformatf("fair%0d", k), 1'b1, WIDTH'(8'h10 + (k % 4)), sel_t'(k % 4));
        end

        // Single requester ch2 (ptr=2 now).
        in_valid = 4'b0100;
        set_data(2, 8'hA5);
        #1;
        check("single.ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("single", 1'b1, 8'hA5, 2'd2);

        // Idle: output drops, data/sel hold.
        in_valid = 4'b0000;
        #1;
        check("idle.ready", 32'(in_ready), 32'h0);
        tick();
        check_out("idle", 1'b0, 8'hA5, 2'd2);

        // Wrap/skip: ch3 then only ch1.
        in_valid = 4'b1000;
        set_data(3, 8'h33);
        #1;
        check("wrap3.ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("wrap3", 1'b1, 8'h33, 2'd3);
        in_valid = 4'b0010;
        set_data(1, 8'h11);
        #1;
        check("skip1.ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("skip1", 1'b1, 8'h11, 2'd1);

        // Backpressure for 3 cycles holding the sel=1 beat.
        for (int i = 0; i < NUM_IN; i++) set_data(i, WIDTH'(8'h20 + i));
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.ready", k), 32'(in_ready), 32'h0);
            tick();
            check_out($sformatf("bp%0d", k), 1'b1, 8'h11, 2'd1);
        end
        // Release: drain and load same edge; ptr=2 picks ch2.
        out_ready = 1'b1;
        #1;
        check("bprel.ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("bprel", 1'b1, 8'h22, 2'd2);

        // Empty output register accepts even with out_ready=0; ptr=3 wraps to ch0.
        in_valid = 4'b0000;
        tick();
        check("drain.valid", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        #1;
        check("emptyload.ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("emptyload", 1'b1, 8'h20, 2'd0);
        #1;
        check("full.ready", 32'(in_ready), 32'h0);

        // Reset mid-operation discards the held beat and returns ptr to 0.
        in_valid = 4'b1111;
        rst      = 1'b1;
        tick();
        check("midrst.valid", 32'(out_valid), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1010;
        #1;
        check("midrst.ptr", 32'(in_ready), 32'b0010);

`ifdef MUX4_RR_LOCK_EN
        // Lock: ch0 sends 3 beats (last on third) with ch1 requesting throughout.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 4'b0011;
        in_last  = 4'b0010;
        set_data(0, 8'hC0);
        set_data(1, 8'hC1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) in_last[0] = 1'b1;
            #1;
            check($sformatf("lock%0d.ready", k), 32'(in_ready), 32'b0001);
            tick();
            check_out($sformatf("lock%0d", k), 1'b1, 8'hC0, 2'd0);
            check($sformatf("lock%0d.last", k), 32'(out_last), 32'(k == 2));
        end
        #1;
        check("lock3.ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("lock3", 1'b1, 8'hC1, 2'd1);

        // Reset while locked on ch2 (ptr=2): afterwards ARB with ptr=0.
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        tick();
        check("lk2.sel", 32'(out_sel), 32'd2);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 4'b1010;
        #1;
        check("lkrst.ready", 32'(in_ready), 32'b0010);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr.md
# mux4_rr

Four-input round-robin arbitrated multiplexer with valid/ready handshakes on every port and a registered output stage. It gathers four producer channels onto one consumer channel. It emits a 2-bit select tag with each beat, so a downstream 1:4 demux can route responses back to the originating channel. It is the gathering counterpart of the channel demux and sits between the four channel sources and the shared datapath.

## Interface
- WIDTH, 8, data width per channel
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  4  per-channel valid
- in_data  in  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  4  per-channel ready; at most one bit set
- in_last  in  4  per-channel end-of-packet; present only with MUX4_RR_LOCK_EN
- out_valid  out  1  output beat valid
- out_data  out  WIDTH  output beat data
- out_sel  out  2  index of the channel that produced the beat
- out_last  out  1  registered copy of winning in_last; present only with MUX4_RR_LOCK_EN
- out_ready  in  1  consumer accepts the beat

## Operation
- Registered state:
  - out_valid, out_data, out_sel
  - 2-bit round-robin pointer ptr
  - lock state, when configured
- load_en = !out_valid | out_ready. The output register is free or is draining this cycle.
- Grant: the first channel with in_valid=1, searching ptr, ptr+1, … mod 4. Wrap-around from 3 to 0 is required.
- in_ready[g] = load_en & grant[g]. All other bits of in_ready are 0. in_ready is combinational from in_valid, ptr, out_valid and out_ready.
- A transfer on channel g (in_valid[g] & in_ready[g]) does the following at the next edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= g+1 mod 4
- If load_en=1 and no channel is valid:
  - out_valid <= 0
  - out_data and out_sel hold their previous values
  - ptr holds
- If out_valid=1 and out_ready=0:
  - out_data and out_sel are held stable
  - in_ready=0000
  - ptr holds
- Simultaneous drain and load (out_ready=1 with a valid requester) gives back-to-back beats with no bubble.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, ptr=0, state=ARB
  - in_ready is forced to 0000 while rst=1
- Reset mid-operation discards the held beat and any lock in the following cycle.

## Timing
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle when out_ready is held at 1.
- No combinational path from in_data to out_data.
- The only combinational path from out_ready to in_ready is through load_en.
- A consumer may drop out_ready at any time. A beat is consumed only on a cycle where out_valid & out_ready.

## Configuration
- MUX4_RR_LOCK_EN undefined:
  - in_last and out_last do not exist
  - arbitration happens on every beat
- MUX4_RR_LOCK_EN defined, two-state FSM:
  - ARB: grant as above. A transfer with in_last[g]=0 moves to LOCKED and records lock_ch=g. A transfer with in_last[g]=1 stays in ARB.
  - LOCKED: the grant is forced to lock_ch regardless of other requests. Bubbles are allowed while in_valid[lock_ch]=0. A transfer with in_last=1 returns to ARB.
  - ptr updates to lock_ch+1 only on the last beat of the packet.
  - out_last <= in_last[g] on each transfer.

## Structure
- Package mux4_rr_pkg holds:
  - NUM_IN=4
  - SEL_W=2
  - typedef sel_t (logic [SEL_W-1:0])
  - FSM state enum {ARB, LOCKED}
- Sub-module rr_arbiter4 is purely combinational.
  - Inputs: req[3:0], ptr.
  - Outputs: one-hot grant[3:0], encoded grant_idx, any_grant.
- The top level holds the output register, the pointer, and the lock FSM.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1111 → out_valid=0, out_sel=0, in_ready=0000. First grant after release is channel 0.
- Single requester: in_valid=0100, in_data ch2=0xA5, out_ready=1 → in_ready=0100; next cycle out_valid=1, out_data=0xA5, out_sel=2.
- Fairness: in_valid=1111 held, out_ready=1 → out_sel sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Wrap/skip: grant ch3, then only in_valid=0010 → next grant ch1, then ptr=2.
- Backpressure: out_valid=1, out_sel=1, out_ready=0 for 3 cycles → out_data stable, in_ready=0000. Raising out_ready → beat consumed and next grant loaded in the same cycle.
- Lock (MUX4_RR_LOCK_EN): ch0 sends 3 beats with in_last on the third, ch1 valid throughout → out_sel 0,0,0,1, out_last 0,0,1,x. Applying rst mid-packet → state ARB and ptr=0.
